// File: rtl/vga_text_console_writer.sv
// vga_text_console_writer
//   Avalon-MM write master that feeds the VGA text-mode slave. It turns a
//   byte stream into VRAM writes while tracking a cursor over the character
//   grid. Printable codes become single-lane writes with no read-modify-write.
//   LF, CR and BS only move the cursor. FF clears the whole screen. The
//   control register word (NUM_COLS*NUM_ROWS/4) is never addressed.
//
//   Optional feature: define VGA_CONSOLE_CLEAR_ROW_EN to blank each new row.
//   The row is blanked whenever the cursor moves to it through LF or through
//   end-of-row wrap.
//
// Ports
//   CLK, RESET        clock; synchronous active-high reset
//   CHAR_VALID/DATA/INV  input byte stream (INV sampled with DATA)
//   CHAR_READY        byte accepted on edge with CHAR_VALID & CHAR_READY
//   AVM_*             Avalon-MM write master (word address, byte enables)
//   CURSOR_COL/ROW    current cursor position
//   BUSY              a write or clear is in progress
module vga_text_console_writer #(
  parameter int          NUM_COLS   = 80,
  parameter int          NUM_ROWS   = 30,
  parameter logic [7:0]  CLEAR_CODE = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  input  logic [7:0]  CHAR_DATA,
  input  logic        CHAR_INV,
  output logic        CHAR_READY,
  output logic        AVM_WRITE,
  output logic [9:0]  AVM_ADDR,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic        AVM_WAITREQUEST,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW,
  output logic        BUSY
);

  localparam int WPR   = NUM_COLS / 4;      // words per row
  localparam int WORDS = WPR * NUM_ROWS;    // text words below the control register

`ifdef VGA_CONSOLE_CLEAR_ROW_EN
  typedef enum logic [1:0] {IDLE, WR_CHAR, CLR_SCREEN, CLR_ROW} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR_CHAR, CLR_SCREEN} state_t;
`endif

  state_t     state;
  logic [9:0] clr_last;   // final word address of the clear in progress
  logic [4:0] row_inc;

  function automatic logic [9:0] row_base(input logic [4:0] r);
    return 10'(int'(r) * WPR);
  endfunction

  assign row_inc = (CURSOR_ROW == 5'(NUM_ROWS - 1)) ? '0 : CURSOR_ROW + 5'd1;
  assign BUSY    = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      CHAR_READY    <= 1'b0;
      AVM_WRITE     <= 1'b0;
      AVM_ADDR      <= '0;
      AVM_BYTE_EN   <= '0;
      AVM_WRITEDATA <= '0;
      CURSOR_COL    <= '0;
      CURSOR_ROW    <= '0;
      clr_last      <= '0;
    end else begin
      case (state)
        IDLE: begin
          CHAR_READY <= 1'b1;
          if (CHAR_VALID && CHAR_READY) begin
            case (CHAR_DATA)
              8'h0A: begin
                CURSOR_COL <= '0;
                CURSOR_ROW <= row_inc;
`ifdef VGA_CONSOLE_CLEAR_ROW_EN
                state         <= CLR_ROW;
                CHAR_READY    <= 1'b0;
                AVM_WRITE     <= 1'b1;
                AVM_ADDR      <= row_base(row_inc);
                clr_last      <= row_base(row_inc) + 10'(WPR - 1);
                AVM_BYTE_EN   <= 4'hF;
                AVM_WRITEDATA <= {4{CLEAR_CODE}};
`endif
              end
              8'h0D: CURSOR_COL <= '0;
              8'h08: if (CURSOR_COL != '0) CURSOR_COL <= CURSOR_COL - 7'd1;
              8'h0C: begin
                state         <= CLR_SCREEN;
                CHAR_READY    <= 1'b0;
                AVM_WRITE     <= 1'b1;
                AVM_ADDR      <= '0;
                clr_last      <= 10'(WORDS - 1);
                AVM_BYTE_EN   <= 4'hF;
                AVM_WRITEDATA <= {4{CLEAR_CODE}};
              end
              default: begin
                state         <= WR_CHAR;
                CHAR_READY    <= 1'b0;
                AVM_WRITE     <= 1'b1;
                AVM_ADDR      <= row_base(CURSOR_ROW) + 10'(CURSOR_COL[6:2]);
                AVM_BYTE_EN   <= 4'b0001 << CURSOR_COL[1:0];
                AVM_WRITEDATA <= {4{CHAR_INV, CHAR_DATA[6:0]}};
              end
            endcase
          end
        end

        WR_CHAR: begin
          if (!AVM_WAITREQUEST) begin
            AVM_WRITE  <= 1'b0;
            state      <= IDLE;
            CHAR_READY <= 1'b1;
            if (CURSOR_COL == 7'(NUM_COLS - 1)) begin
              CURSOR_COL <= '0;
              CURSOR_ROW <= row_inc;
`ifdef VGA_CONSOLE_CLEAR_ROW_EN
              // End-of-row wrap chains straight into blanking the new row.
              state         <= CLR_ROW;
              CHAR_READY    <= 1'b0;
              AVM_WRITE     <= 1'b1;
              AVM_ADDR      <= row_base(row_inc);
              clr_last      <= row_base(row_inc) + 10'(WPR - 1);
              AVM_BYTE_EN   <= 4'hF;
              AVM_WRITEDATA <= {4{CLEAR_CODE}};
`endif
            end else begin
              CURSOR_COL <= CURSOR_COL + 7'd1;
            end
          end
        end

        CLR_SCREEN: begin
          if (!AVM_WAITREQUEST) begin
            if (AVM_ADDR == clr_last) begin
              AVM_WRITE  <= 1'b0;
              state      <= IDLE;
              CHAR_READY <= 1'b1;
              CURSOR_COL <= '0;
              CURSOR_ROW <= '0;
            end else begin
              AVM_ADDR <= AVM_ADDR + 10'd1;
            end
          end
        end

`ifdef VGA_CONSOLE_CLEAR_ROW_EN
        CLR_ROW: begin
          if (!AVM_WAITREQUEST) begin
            if (AVM_ADDR == clr_last) begin
              AVM_WRITE  <= 1'b0;
              state      <= IDLE;
              CHAR_READY <= 1'b1;
            end else begin
              AVM_ADDR <= AVM_ADDR + 10'd1;
            end
          end
        end
`endif

        default: begin
          state     <= IDLE;
          AVM_WRITE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_console_writer.sv
module tb_vga_text_console_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int WPR   = COLS / 4;
  localparam int WORDS = WPR * ROWS;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        CHAR_VALID = 1'b0;
  logic [7:0]  CHAR_DATA = '0;
  logic        CHAR_INV = 1'b0;
  logic        CHAR_READY;
  logic        AVM_WRITE;
  logic [9:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST = 1'b0;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;
  logic        BUSY;

  vga_text_console_writer #(.NUM_COLS(COLS), .NUM_ROWS(ROWS), .CLEAR_CODE(8'h00)) dut (
    .CLK(clk), .RESET(RESET), .CHAR_VALID(CHAR_VALID), .CHAR_DATA(CHAR_DATA),
    .CHAR_INV(CHAR_INV), .CHAR_READY(CHAR_READY), .AVM_WRITE(AVM_WRITE),
    .AVM_ADDR(AVM_ADDR), .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITEDATA(AVM_WRITEDATA),
    .AVM_WAITREQUEST(AVM_WAITREQUEST), .CURSOR_COL(CURSOR_COL),
    .CURSOR_ROW(CURSOR_ROW), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_writes = 0;
  int  max_addr = 0;
  int  m_col = 0;
  int  m_row = 0;
  int  stall_pct = 0;
  int  force_stall = 0;
  logic hold_valid = 1'b0;
  wr_t  held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: terminal semantics applied to an expected write list.
  function automatic void push_row_clear(input int r);
    for (int i = 0; i < WPR; i++) exp_q.push_back('{10'(r * WPR + i), 4'hF, 32'h0});
  endfunction

  function automatic void model_byte(input logic [7:0] d, input logic inv);
    logic [7:0] lane;
    case (d)
      8'h0A: begin
        m_col = 0; m_row = (m_row + 1) % ROWS;
`ifdef VGA_CONSOLE_CLEAR_ROW_EN
        push_row_clear(m_row);
`endif
      end
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) m_col = m_col - 1;
      8'h0C: begin
        for (int i = 0; i < WORDS; i++) exp_q.push_back('{10'(i), 4'hF, 32'h0});
        m_col = 0; m_row = 0;
      end
      default: begin
        lane = {inv, d[6:0]};
        exp_q.push_back('{10'(m_row * WPR + m_col / 4), 4'(1 << (m_col % 4)),
                         {lane, lane, lane, lane}});
        m_col = m_col + 1;
        if (m_col == COLS) begin
          m_col = 0; m_row = (m_row + 1) % ROWS;
`ifdef VGA_CONSOLE_CLEAR_ROW_EN
          push_row_clear(m_row);
`endif
        end
      end
    endcase
  endfunction

  // Slave side: choose waitrequest for the coming edge, then score the bus.
  always @(negedge clk) begin
    logic w;
    wr_t  cur;
    if (force_stall > 0 && AVM_WRITE) begin
      w = 1'b1; force_stall--;
    end else begin
      w = ($urandom_range(0, 99) < stall_pct);
    end
    AVM_WAITREQUEST = w;
    cur = '{AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA};
    if (RESET || !AVM_WRITE) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) check("stall_hold", 64'(cur), 64'(held));
      if (w) begin
        hold_valid = 1'b1; held = cur;
      end else begin
        hold_valid = 1'b0;
        n_writes++;
        if (int'(AVM_ADDR) > max_addr) max_addr = int'(AVM_ADDR);
        check("addr_range", 64'(AVM_ADDR < 10'(WORDS)), 64'd1);
        if (exp_q.size() == 0) check("spurious_write", 64'(cur), 64'h0 - 1);
        else check("write", 64'(cur), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (!(CHAR_READY && !BUSY) && n < 5000) begin @(negedge clk); n++; end
    if (!(CHAR_READY && !BUSY)) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic inv);
    int unsigned n = 0;
    @(negedge clk);
    while (!CHAR_READY && n < 5000) begin @(negedge clk); n++; end
    if (!CHAR_READY) begin
      check("ready_timeout", 64'd0, 64'd1);
      return;
    end
    model_byte(d, inv);
    CHAR_VALID = 1'b1; CHAR_DATA = d; CHAR_INV = inv;
    @(posedge clk); #1;
    CHAR_VALID = 1'b0;
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, 64'(CURSOR_COL), 64'(m_col));
    check({tag, "_row"}, 64'(CURSOR_ROW), 64'(m_row));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic ready_hi;
    logic [7:0] d;
    int r;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(CHAR_READY), 64'd0);
    check("rst_write", 64'(AVM_WRITE), 64'd0);
    check("rst_addr", 64'(AVM_ADDR), 64'd0);
    check("rst_be", 64'(AVM_BYTE_EN), 64'd0);
    check("rst_data", 64'(AVM_WRITEDATA), 64'd0);
    check("rst_col", 64'(CURSOR_COL), 64'd0);
    check("rst_row", 64'(CURSOR_ROW), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    RESET = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(CHAR_READY), 64'd1);

    // 'A' with zero wait: write next cycle, ready back two cycles after accept
    send_byte(8'h41, 1'b0);
    @(negedge clk);
    check("a_write", 64'(AVM_WRITE), 64'd1);
    check("a_ready_low", 64'(CHAR_READY), 64'd0);
    @(negedge clk);
    check("a_ready_back", 64'(CHAR_READY), 64'd1);
    check("a_write_done", 64'(AVM_WRITE), 64'd0);
    check_cursor("a");

    // Move to (5,3), then 0xC2 inverse with 3 stall cycles
    send_byte(8'h0D, 1'b0);
    repeat (3) send_byte(8'h0A, 1'b0);
    repeat (5) send_byte(8'(32 + $urandom_range(0, 90)), 1'($urandom_range(0, 1)));
    wait_idle();
    check_cursor("at53");
    w0 = n_writes;
    force_stall = 3;
    send_byte(8'hC2, 1'b1);
    wait_idle();
    check("c2_one_write", 64'(n_writes - w0), 64'd1);
    check_cursor("c2");

    // 80 printables from (0,29) with random stalls
    send_byte(8'h0D, 1'b0);
    while (m_row != 29) send_byte(8'h0A, 1'b0);
    wait_idle();
    max_addr = 0;
    stall_pct = 30;
    repeat (80) send_byte(8'(33 + $urandom_range(0, 90)), 1'($urandom_range(0, 1)));
    wait_idle();
    check("wrap_max_addr", 64'(max_addr), 64'(WORDS - 1));
    check_cursor("wrap");

    // Form feed: ready stays low throughout the clear
    stall_pct = 0;
    send_byte(8'h41, 1'b0);
    send_byte(8'h0C, 1'b0);
    ready_hi = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5000 && BUSY; i++) begin
      if (CHAR_READY) ready_hi = 1'b1;
      @(negedge clk);
    end
    check("ff_ready_low", 64'(ready_hi), 64'd0);
    check("ff_queue_drained", 64'(exp_q.size()), 64'd0);
    check_cursor("ff");

    // LF, CR, BS from (0,0), then 'x' at word 20 lane 0
    w0 = n_writes;
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0D, 1'b0);
    send_byte(8'h08, 1'b0);
    wait_idle();
`ifdef VGA_CONSOLE_CLEAR_ROW_EN
    check("ctl_writes", 64'(n_writes - w0), 64'(WPR));
`else
    check("ctl_writes", 64'(n_writes - w0), 64'd0);
`endif
    send_byte(8'h78, 1'b0);
    wait_idle();
    check_cursor("x");

    // Random traffic
    stall_pct = 25;
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      if (r < 6) d = 8'h0A;
      else if (r < 10) d = 8'h0D;
      else if (r < 16) d = 8'h08;
      else if (r == 16) d = 8'h0C;
      else d = 8'($urandom_range(0, 255));
      send_byte(d, 1'($urandom_range(0, 1)));
      wait_idle();
      check_cursor("rand");
    end

    // Reset in the middle of a screen clear
    stall_pct = 0;
    send_byte(8'h0C, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    RESET = 1'b1;
    exp_q.delete();
    m_col = 0; m_row = 0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_write", 64'(AVM_WRITE), 64'd0);
    check("midrst_ready", 64'(CHAR_READY), 64'd0);
    check_cursor("midrst");
    RESET = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", 64'(CHAR_READY), 64'd1);
    check("midrst_busy", 64'(BUSY), 64'd0);

    send_byte(8'h5A, 1'b1);
    wait_idle();
    check_cursor("post_rst");
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
